// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between NUM_CH
// AXI-Stream byte sources. A grant is held until tlast is sent or the granted
// channel idles for IDLE_TIMEOUT cycles mid-packet.
// Optional build macro: UART_ARB_HDR_EN sends a header byte {4'hA, grant_id}
// before each packet's payload.
module uart_tx_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned IDLE_TIMEOUT = 1024,
    localparam int unsigned GrantW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATA_BITS-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]           s_axis_tvalid,
    input  logic [NUM_CH-1:0]           s_axis_tlast,
    output logic [NUM_CH-1:0]           s_axis_tready,
    output logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [GrantW-1:0]           grant_id,
    output logic                        pkt_active,
    output logic                        timeout_err
);

    localparam int unsigned CntW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
`ifdef UART_ARB_HDR_EN
        StHdr,
`endif
        StSend,
        StLaunch,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [GrantW-1:0]      grant_q, grant_d;
    logic [GrantW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                   pkt_active_q, pkt_active_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   last_q, last_d;
    logic [CntW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   found;
    logic [GrantW-1:0]      winner;
    logic                   g_valid;
    logic                   g_last;
    logic [DATA_BITS-1:0]   g_data;

`ifdef UART_ARB_HDR_EN
    logic [7:0]             hdr_byte;
    assign hdr_byte = {4'hA, 4'(grant_q)};
`endif

    // Granted channel's stream signals.
    assign g_valid = s_axis_tvalid[grant_q];
    assign g_last  = s_axis_tlast[grant_q];
    assign g_data  = s_axis_tdata[int'(grant_q)*DATA_BITS +: DATA_BITS];

    // Round-robin search starting just after the last released channel.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (!found && s_axis_tvalid[idx]) begin
                found  = 1'b1;
                winner = GrantW'(idx);
            end
        end
    end

    // Next-state, grant bookkeeping and the combinational tready.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        pkt_active_d  = pkt_active_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        s_axis_tready = '0;

        case (state_q)
            StIdle: begin
                if (|s_axis_tvalid) state_d = StArb;
            end
            StArb: begin
                // Requests may have withdrawn since IDLE; fall back without a grant.
                if (found) begin
                    grant_d      = winner;
                    pkt_active_d = 1'b1;
                    idle_cnt_d   = '0;
`ifdef UART_ARB_HDR_EN
                    state_d      = StHdr;
`else
                    state_d      = StSend;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
`ifdef UART_ARB_HDR_EN
            StHdr: begin
                // last_d cleared so DRAIN always continues into the payload.
                if (!tx_busy) begin
                    tx_data_d = DATA_BITS'(hdr_byte);
                    last_d    = 1'b0;
                    state_d   = StLaunch;
                end
            end
`endif
            StSend: begin
                if (g_valid) begin
                    if (!tx_busy) begin
                        s_axis_tready[grant_q] = 1'b1;
                        tx_data_d  = g_data;
                        last_d     = g_last;
                        idle_cnt_d = '0;
                        state_d    = StLaunch;
                    end
                end else begin
                    if (idle_cnt_q != CntMax) idle_cnt_d = idle_cnt_q + 1'b1;
                    if (IDLE_TIMEOUT != 0 && idle_cnt_q == TimeoutLast) begin
                        timeout_err_d = 1'b1;
                        rr_ptr_d      = grant_q;
                        pkt_active_d  = 1'b0;
                        state_d       = StIdle;
                    end
                end
            end
            StLaunch: begin
                state_d = StDrain;
            end
            StDrain: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        rr_ptr_d     = grant_q;
                        pkt_active_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            rr_ptr_q      <= GrantW'(NUM_CH - 1);
            pkt_active_q  <= 1'b0;
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            pkt_active_q  <= pkt_active_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_start    = (state_q == StLaunch);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign pkt_active  = pkt_active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: AXIS source models per channel, a
// transmitter model holding busy for a fixed frame time, and a scoreboard of
// expected (channel, byte) launches. Honours UART_ARB_HDR_EN when defined.
module tb_uart_tx_arbiter;

    localparam int unsigned NCH  = 4;
    localparam int unsigned DB   = 8;
    localparam int unsigned TO   = 16;
    localparam int          BUSY = 20;
`ifdef UART_ARB_HDR_EN
    localparam int          HDR  = 1;
`else
    localparam int          HDR  = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DB-1:0] s_axis_tdata;
    logic [NCH-1:0]    s_axis_tvalid;
    logic [NCH-1:0]    s_axis_tlast;
    logic [NCH-1:0]    s_axis_tready;
    logic [DB-1:0]     tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              pkt_active;
    logic              timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_CH       (NCH),
        .DATA_BITS    (DB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .pkt_active    (pkt_active),
        .timeout_err   (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Per-channel source FIFOs: {tlast, tdata}.
    logic [8:0] src_mem [NCH][16];
    int         src_wr  [NCH];
    int         src_rd  [NCH];
    logic       busy_force = 1'b0;

    // Scoreboard of expected launches.
    int exp_ch[$];
    int exp_data[$];

    // Monitor-maintained statistics.
    int n_start = 0;
    int n_terr = 0;
    int n_viol = 0;
    int terr_delta = 0;
    int pkt_fall_delta = 0;

    task automatic push_byte(input int ch, input int data, input bit last);
        src_mem[ch][src_wr[ch] % 16] = {last, data[7:0]};
        src_wr[ch]++;
    endtask

    // Queue an n-byte packet (bytes base, base+0x11, ...) and its expected launches.
    task automatic send_pkt(input int ch, input int n, input int base, input bit last);
        if (HDR != 0) begin
            exp_ch.push_back(ch);
            exp_data.push_back(8'hA0 | ch);
        end
        for (int i = 0; i < n; i++) begin
            push_byte(ch, (base + i * 8'h11) & 8'hFF, last && (i == n - 1));
            exp_ch.push_back(ch);
            exp_data.push_back((base + i * 8'h11) & 8'hFF);
        end
    endtask

    task automatic drive_src();
        for (int ch = 0; ch < int'(NCH); ch++) begin
            if (src_rd[ch] != src_wr[ch]) begin
                s_axis_tvalid[ch]           = 1'b1;
                s_axis_tdata[ch*DB +: DB]   = src_mem[ch][src_rd[ch] % 16][7:0];
                s_axis_tlast[ch]            = src_mem[ch][src_rd[ch] % 16][8];
            end else begin
                s_axis_tvalid[ch]           = 1'b0;
                s_axis_tdata[ch*DB +: DB]   = '0;
                s_axis_tlast[ch]            = 1'b0;
            end
        end
    endtask

    function automatic bit src_empty();
        for (int ch = 0; ch < int'(NCH); ch++)
            if (src_rd[ch] != src_wr[ch]) return 1'b0;
        return 1'b1;
    endfunction

    // Source handshakes and transmitter model; inputs change #1 after the edge.
    initial begin
        logic [NCH-1:0] fire;
        logic           started;
        int             busy_cnt;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            src_wr[ch] = 0;
            src_rd[ch] = 0;
        end
        drive_src();
        forever begin
            @(negedge clk);
            fire    = s_axis_tvalid & s_axis_tready;
            started = tx_start;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                for (int ch = 0; ch < int'(NCH); ch++)
                    if (fire[ch]) src_rd[ch]++;
                if (started) busy_cnt = BUSY;
                else if (busy_cnt > 0) busy_cnt--;
            end
            tx_busy = (busy_cnt != 0) || busy_force;
            drive_src();
        end
    end

    // Output monitor: scoreboard pops, tready legality, timing of falls/pulses.
    initial begin
        int         cyc;
        int         busy_fall;
        logic       busy_prev;
        logic       pkt_prev;
        logic [7:0] launched;
        cyc = 0; busy_fall = 0; busy_prev = 1'b0; pkt_prev = 1'b0; launched = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                launched = '0;
            end else begin
                if (tx_start) begin
                    n_start++;
                    if (exp_data.size() == 0) begin
                        check_eq("sb_has_entry_at_start", exp_data.size(), 1);
                    end else begin
                        check_eq("tx_data", tx_data, exp_data.pop_front());
                        check_eq("grant_at_start", grant_id, exp_ch.pop_front());
                    end
                    launched = tx_data;
                end
                if (s_axis_tready != '0) begin
                    check_eq("tready_onehot_granted", s_axis_tready, 1 << grant_id);
                    check_eq("tready_without_valid", s_axis_tready & ~s_axis_tvalid, 0);
                end
                if (busy_force && (s_axis_tready != '0 || tx_start)) n_viol++;
                if (busy_prev && !tx_busy) begin
                    busy_fall = cyc;
                    check_eq("tx_data_hold", tx_data, launched);
                end
                if (pkt_prev && !pkt_active) pkt_fall_delta = cyc - busy_fall;
                if (timeout_err) begin
                    n_terr++;
                    terr_delta = cyc - busy_fall;
                end
            end
            busy_prev = tx_busy;
            pkt_prev  = pkt_active;
        end
    end

    task automatic do_reset(input bit check_vals);
        @(negedge clk);
        rst_n      = 1'b0;
        busy_force = 1'b0;
        for (int ch = 0; ch < int'(NCH); ch++) src_rd[ch] = src_wr[ch];
        exp_ch.delete();
        exp_data.delete();
        repeat (3) @(negedge clk);
        if (check_vals) begin
            check_eq("rst_tx_data", tx_data, 0);
            check_eq("rst_tx_start", tx_start, 0);
            check_eq("rst_tready", s_axis_tready, 0);
            check_eq("rst_grant_id", grant_id, 0);
            check_eq("rst_pkt_active", pkt_active, 0);
            check_eq("rst_timeout_err", timeout_err, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (exp_data.size() == 0 && !pkt_active && src_empty()) done = 1'b1;
        end
        check_eq({tag, "_done"}, done, 1);
    endtask

    initial begin
        int starts0;
        rst_n = 1'b0;
        do_reset(1'b1);

        // Single 3-byte packet on channel 1.
        starts0 = n_start;
        send_pkt(1, 3, 8'h11, 1'b1);
        wait_idle("t1");
        check_eq("t1_starts", n_start - starts0, 3 + HDR);
        check_eq("t1_grant_id_held", grant_id, 1);
        check_eq("t1_pkt_fall_after_drain", pkt_fall_delta, 1);

        // All four channels at once: grants in order 0,1,2,3.
        do_reset(1'b0);
        starts0 = n_start;
        for (int ch = 0; ch < int'(NCH); ch++) send_pkt(ch, 2, 8'h40 + ch * 8'h20, 1'b1);
        wait_idle("t2");
        check_eq("t2_starts", n_start - starts0, 4 * (2 + HDR));

        // Channel 2 re-requests while channel 0 waits: channel 0 goes first.
        do_reset(1'b0);
        send_pkt(2, 1, 8'h21, 1'b1);
        for (int i = 0; i < 200 && exp_data.size() != 0; i++) @(negedge clk);
        check_eq("t3_first_launched", exp_data.size(), 0);
        send_pkt(0, 1, 8'h01, 1'b1);
        send_pkt(2, 1, 8'h22, 1'b1);
        wait_idle("t3");
        check_eq("t3_grant_last", grant_id, 2);

        // Timeout: channel 3 stalls mid-packet, channel 0 pending.
        do_reset(1'b0);
        n_terr = 0;
        send_pkt(3, 1, 8'h33, 1'b0);
        for (int i = 0; i < 200 && exp_data.size() != 0; i++) @(negedge clk);
        check_eq("t4_first_launched", exp_data.size(), 0);
        send_pkt(0, 1, 8'h0A, 1'b1);
        wait_idle("t4");
        check_eq("t4_timeout_pulses", n_terr, 1);
        // Released 16 cycles after DRAIN exits, which is one cycle after busy falls.
        check_eq("t4_timeout_delay", terr_delta, TO + 1);
        check_eq("t4_grant_after_timeout", grant_id, 0);

        // Transmitter busy blocks acceptance.
        do_reset(1'b0);
        n_viol = 0;
        busy_force = 1'b1;
        send_pkt(1, 1, 8'h77, 1'b1);
        repeat (50) @(negedge clk);
        check_eq("t5_no_accept_while_busy", n_viol, 0);
        check_eq("t5_nothing_launched", exp_data.size(), 1 + HDR);
        check_eq("t5_pkt_active_held", pkt_active, 1);
        busy_force = 1'b0;
        wait_idle("t5");

        // Header option: 0x5A on channel 2 (0xA2 precedes it when enabled).
        do_reset(1'b0);
        starts0 = n_start;
        send_pkt(2, 1, 8'h5A, 1'b1);
        wait_idle("t6");
        check_eq("t6_starts", n_start - starts0, 1 + HDR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
